// File: rtl/fetch_mem_unit.sv
// Fetch/memory datapath stage: PC, IR with field decode, MDR and a req/ack
// memory port serialising instruction fetch, data load and data store.
module fetch_mem_unit #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int PC_STEP  = 1,
    parameter int AUTO_INC = 1,
    parameter int RESET_PC = 0,
    parameter int MAX_WAIT = 15
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              fetch_req,
    input  logic              load_req,
    input  logic              store_req,
    input  logic              pc_write,
    input  logic [ADDR_W-1:0] pc_new,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              bus_err,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic [3:0]        ir_op,
    output logic [3:0]        ir_rd,
    output logic [3:0]        ir_ra,
    output logic [3:0]        ir_rb,
    output logic [DATA_W-1:0] ir_imm,
    output logic [DATA_W-1:0] mdr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] LOAD  = 2'd2;
    localparam logic [1:0] STORE = 2'd3;

    function automatic logic [DATA_W-1:0] sext8(input logic [7:0] v);
        return {{(DATA_W-8){v[7]}}, v};
    endfunction

    logic [1:0]        state_r,   state_s;
    logic [ADDR_W-1:0] pc_r,      pc_s;
    logic [DATA_W-1:0] ir_r,      ir_s;
    logic [DATA_W-1:0] mdr_r,     mdr_s;
    logic              req_r,     req_s;
    logic              we_r,      we_s;
    logic [ADDR_W-1:0] addr_r,    addr_s;
    logic [DATA_W-1:0] wdata_r,   wdata_s;
    logic              done_r,    done_s;
    logic              err_r,     err_s;
    logic              busy_r,    busy_s;
    logic [CW-1:0]     cnt_r,     cnt_s;
    logic              fetch_fin_s;
    logic              timeout_s;

    // Next-state logic for the access FSM and every datapath register.
    always_comb begin
        state_s     = state_r;
        ir_s        = ir_r;
        mdr_s       = mdr_r;
        req_s       = req_r;
        we_s        = we_r;
        addr_s      = addr_r;
        wdata_s     = wdata_r;
        cnt_s       = cnt_r;
        done_s      = 1'b0;
        err_s       = 1'b0;
        fetch_fin_s = 1'b0;
        timeout_s   = (MAX_WAIT != 0) && (cnt_r == CW'(MAX_WAIT - 1));

        case (state_r)
            IDLE: begin
                if (fetch_req) begin
                    state_s = FETCH;
                    addr_s  = pc_r;
                    we_s    = 1'b0;
                    req_s   = 1'b1;
                    cnt_s   = '0;
                end else if (load_req) begin
                    state_s = LOAD;
                    addr_s  = alu_addr;
                    we_s    = 1'b0;
                    req_s   = 1'b1;
                    cnt_s   = '0;
                end else if (store_req) begin
                    state_s = STORE;
                    addr_s  = alu_addr;
                    wdata_s = wr_data;
                    we_s    = 1'b1;
                    req_s   = 1'b1;
                    cnt_s   = '0;
                end else begin
                    req_s = 1'b0;
                    we_s  = 1'b0;
                end
            end
            FETCH, LOAD, STORE: begin
                // An ack on the edge the counter would expire still wins.
                if (req_r && mem_ack) begin
                    case (state_r)
                        FETCH: begin
                            ir_s        = mem_rdata;
                            fetch_fin_s = 1'b1;
                        end
                        LOAD:    mdr_s = mem_rdata;
                        default: ir_s  = ir_r;
                    endcase
                    req_s   = 1'b0;
                    we_s    = 1'b0;
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else if (timeout_s) begin
                    req_s   = 1'b0;
                    we_s    = 1'b0;
                    err_s   = 1'b1;
                    state_s = IDLE;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            default: begin
                state_s = IDLE;
                req_s   = 1'b0;
                we_s    = 1'b0;
            end
        endcase

        // pc_write overrides any auto-increment on the same edge.
        pc_s   = pc_write ? pc_new :
                 ((fetch_fin_s && (AUTO_INC != 0)) ? pc_r + ADDR_W'(PC_STEP) : pc_r);
        busy_s = (state_s != IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_r <= IDLE;
            pc_r    <= ADDR_W'(RESET_PC);
            ir_r    <= '0;
            mdr_r   <= '0;
            req_r   <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            ir_r    <= ir_s;
            mdr_r   <= mdr_s;
            req_r   <= req_s;
            we_r    <= we_s;
            addr_r  <= addr_s;
            wdata_r <= wdata_s;
            done_r  <= done_s;
            err_r   <= err_s;
            busy_r  <= busy_s;
            cnt_r   <= cnt_s;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign bus_err   = err_r;
    assign pc        = pc_r;
    assign ir        = ir_r;
    assign mdr       = mdr_r;
    assign mem_req   = req_r;
    assign mem_we    = we_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;

    assign ir_op  = ir_r[DATA_W-1 -: 4];
    assign ir_rd  = ir_r[DATA_W-5 -: 4];
    assign ir_ra  = ir_r[DATA_W-9 -: 4];
    assign ir_rb  = ir_r[3:0];
    assign ir_imm = sext8(ir_r[7:0]);

endmodule

// File: tb/tb_fetch_mem_unit.sv
// Directed bench for fetch_mem_unit: transaction-level model checked every
// cycle, plus literal expectations at the interesting points.
module tb_fetch_mem_unit;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        fetch_req = 1'b0, load_req = 1'b0, store_req = 1'b0, pc_write = 1'b0;
    logic [15:0] pc_new = 16'h0, alu_addr = 16'h0, wr_data = 16'h0;
    logic        busy, done, bus_err;
    logic [15:0] pc, ir, ir_imm, mdr;
    logic [3:0]  ir_op, ir_rd, ir_ra, ir_rb;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = 16'h0;
    logic        mem_ack = 1'b0;

    int total = 0;
    int bad   = 0;

    fetch_mem_unit dut (
        .CLK(CLK), .Reset(Reset),
        .fetch_req(fetch_req), .load_req(load_req), .store_req(store_req),
        .pc_write(pc_write), .pc_new(pc_new), .alu_addr(alu_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .bus_err(bus_err), .pc(pc), .ir(ir),
        .ir_op(ir_op), .ir_rd(ir_rd), .ir_ra(ir_ra), .ir_rb(ir_rb), .ir_imm(ir_imm),
        .mdr(mdr), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: one pending access at most, described by kind,
    // address, data and the number of cycles it has been waiting.
    typedef enum int {K_NONE, K_FETCH, K_LOAD, K_STORE} kind_t;
    kind_t       m_kind = K_NONE;
    int          m_waited = 0;
    bit          model_ok = 1'b0;
    bit          m_done = 1'b0, m_err = 1'b0, m_fetch_fin = 1'b0;
    logic [15:0] m_pc = 16'h0, m_ir = 16'h0, m_mdr = 16'h0;
    logic [15:0] m_addr = 16'h0, m_wdata = 16'h0;

    always @(posedge CLK) begin
        if (Reset) begin
            m_kind = K_NONE; m_waited = 0; m_done = 1'b0; m_err = 1'b0;
            m_pc = 16'h0; m_ir = 16'h0; m_mdr = 16'h0; m_addr = 16'h0; m_wdata = 16'h0;
            model_ok = 1'b1;
        end else begin
            m_done = 1'b0; m_err = 1'b0; m_fetch_fin = 1'b0;
            if (m_kind != K_NONE) begin
                if (mem_ack) begin
                    if (m_kind == K_FETCH) begin m_ir = mem_rdata; m_fetch_fin = 1'b1; end
                    if (m_kind == K_LOAD) m_mdr = mem_rdata;
                    m_kind = K_NONE;
                    m_done = 1'b1;
                end else begin
                    m_waited++;
                    if (m_waited == 15) begin m_kind = K_NONE; m_err = 1'b1; end
                end
            end else if (fetch_req) begin
                m_kind = K_FETCH; m_addr = m_pc; m_waited = 0;
            end else if (load_req) begin
                m_kind = K_LOAD; m_addr = alu_addr; m_waited = 0;
            end else if (store_req) begin
                m_kind = K_STORE; m_addr = alu_addr; m_wdata = wr_data; m_waited = 0;
            end
            if (pc_write) m_pc = pc_new;
            else if (m_fetch_fin) m_pc = m_pc + 16'd1;
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge CLK) begin
        if (model_ok) begin
            check("busy",      {31'd0, busy},    {31'd0, m_kind != K_NONE});
            check("mem_req",   {31'd0, mem_req}, {31'd0, m_kind != K_NONE});
            check("mem_we",    {31'd0, mem_we},  {31'd0, m_kind == K_STORE});
            check("done",      {31'd0, done},    {31'd0, m_done});
            check("bus_err",   {31'd0, bus_err}, {31'd0, m_err});
            check("pc",        {16'd0, pc},      {16'd0, m_pc});
            check("ir",        {16'd0, ir},      {16'd0, m_ir});
            check("mdr",       {16'd0, mdr},     {16'd0, m_mdr});
            check("mem_addr",  {16'd0, mem_addr},  {16'd0, m_addr});
            check("mem_wdata", {16'd0, mem_wdata}, {16'd0, m_wdata});
            check("ir_op",  {28'd0, ir_op}, {28'd0, m_ir[15:12]});
            check("ir_rd",  {28'd0, ir_rd}, {28'd0, m_ir[11:8]});
            check("ir_ra",  {28'd0, ir_ra}, {28'd0, m_ir[7:4]});
            check("ir_rb",  {28'd0, ir_rb}, {28'd0, m_ir[3:0]});
            check("ir_imm", {16'd0, ir_imm}, {16'd0, {{8{m_ir[7]}}, m_ir[7:0]}});
        end
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic ack_with(input logic [15:0] data);
        mem_ack = 1'b1; mem_rdata = data;
        tick();
        mem_ack = 1'b0; mem_rdata = 16'h0;
    endtask

    initial begin
        ticks(2);
        Reset = 1'b0;
        check("rst_pc",   {16'd0, pc}, 32'h0);
        check("rst_ir",   {16'd0, ir}, 32'h0);
        check("rst_mdr",  {16'd0, mdr}, 32'h0);
        check("rst_req",  {31'd0, mem_req}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);

        // Fetch with three wait cycles.
        pc_write = 1'b1; pc_new = 16'h0010; tick(); pc_write = 1'b0;
        check("pcw", {16'd0, pc}, 32'h0010);
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        check("f1_req", {31'd0, mem_req}, 32'h1);
        check("f1_addr0", {16'd0, mem_addr}, 32'h0010);
        ticks(3);
        check("f1_addr3", {16'd0, mem_addr}, 32'h0010);
        ack_with(16'h3A5F);
        check("f1_done", {31'd0, done}, 32'h1);
        check("f1_ir", {16'd0, ir}, 32'h3A5F);
        check("f1_op", {28'd0, ir_op}, 32'h3);
        check("f1_rd", {28'd0, ir_rd}, 32'hA);
        check("f1_ra", {28'd0, ir_ra}, 32'h5);
        check("f1_rb", {28'd0, ir_rb}, 32'hF);
        check("f1_imm", {16'd0, ir_imm}, 32'h005F);
        check("f1_pc", {16'd0, pc}, 32'h0011);
        check("f1_busy", {31'd0, busy}, 32'h0);
        tick();
        check("f1_done_gone", {31'd0, done}, 32'h0);

        // Zero-wait load, then a fetch producing a negative immediate.
        alu_addr = 16'h0200; load_req = 1'b1; tick(); load_req = 1'b0;
        check("ld_addr", {16'd0, mem_addr}, 32'h0200);
        ack_with(16'h80F0);
        check("ld_mdr", {16'd0, mdr}, 32'h80F0);
        check("ld_pc", {16'd0, pc}, 32'h0011);
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        ack_with(16'h12F0);
        check("neg_imm", {16'd0, ir_imm}, 32'hFFF0);
        check("f2_pc", {16'd0, pc}, 32'h0012);

        // Store with inputs changing during the wait.
        alu_addr = 16'h0300; wr_data = 16'hBEEF; store_req = 1'b1; tick(); store_req = 1'b0;
        alu_addr = 16'h0999; wr_data = 16'h1234;
        ticks(2);
        check("st_we", {31'd0, mem_we}, 32'h1);
        check("st_addr", {16'd0, mem_addr}, 32'h0300);
        check("st_wdata", {16'd0, mem_wdata}, 32'hBEEF);
        ack_with(16'h0000);
        check("st_done", {31'd0, done}, 32'h1);
        check("st_we_off", {31'd0, mem_we}, 32'h0);
        tick();
        check("st_done_once", {31'd0, done}, 32'h0);

        // Fetch beats load; busy-time load ignored; pc wraps.
        pc_write = 1'b1; pc_new = 16'hFFFF; tick(); pc_write = 1'b0;
        alu_addr = 16'h0400; fetch_req = 1'b1; load_req = 1'b1; tick(); fetch_req = 1'b0;
        check("pri_we", {31'd0, mem_we}, 32'h0);
        check("pri_addr", {16'd0, mem_addr}, 32'hFFFF);
        tick(); load_req = 1'b0;
        ack_with(16'h1111);
        check("wrap_pc", {16'd0, pc}, 32'h0000);
        check("pri_ir", {16'd0, ir}, 32'h1111);
        check("pri_mdr", {16'd0, mdr}, 32'h80F0);
        // Back-to-back fetch in the done cycle.
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        check("b2b_busy", {31'd0, busy}, 32'h1);
        check("b2b_addr", {16'd0, mem_addr}, 32'h0000);
        ack_with(16'h2222);
        check("b2b_pc", {16'd0, pc}, 32'h0001);

        // Timeout after 15 wait cycles.
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        ticks(14);
        check("to_req14", {31'd0, mem_req}, 32'h1);
        tick();
        check("to_req15", {31'd0, mem_req}, 32'h0);
        check("to_err", {31'd0, bus_err}, 32'h1);
        check("to_nodone", {31'd0, done}, 32'h0);
        check("to_ir", {16'd0, ir}, 32'h2222);
        check("to_pc", {16'd0, pc}, 32'h0001);
        tick();
        check("to_err_once", {31'd0, bus_err}, 32'h0);
        // Ack on the expiry edge counts as success.
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        ticks(14);
        ack_with(16'h3333);
        check("edge_done", {31'd0, done}, 32'h1);
        check("edge_noerr", {31'd0, bus_err}, 32'h0);
        check("edge_ir", {16'd0, ir}, 32'h3333);
        check("edge_pc", {16'd0, pc}, 32'h0002);

        // pc_write during a fetch and on its completion edge.
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        pc_write = 1'b1; pc_new = 16'h0040; tick(); pc_write = 1'b0;
        check("pcw_hold_addr", {16'd0, mem_addr}, 32'h0002);
        pc_write = 1'b1; pc_new = 16'h0050;
        ack_with(16'h4444);
        pc_write = 1'b0;
        check("pcw_wins", {16'd0, pc}, 32'h0050);
        check("pcw_ir", {16'd0, ir}, 32'h4444);

        // Reset mid-fetch, then a late ack.
        fetch_req = 1'b1; tick(); fetch_req = 1'b0;
        tick();
        Reset = 1'b1; tick(); Reset = 1'b0;
        check("mr_req", {31'd0, mem_req}, 32'h0);
        check("mr_ir", {16'd0, ir}, 32'h0);
        check("mr_pc", {16'd0, pc}, 32'h0);
        ack_with(16'h5555);
        check("mr_nodone", {31'd0, done}, 32'h0);
        check("mr_noerr", {31'd0, bus_err}, 32'h0);
        check("mr_ir_late", {16'd0, ir}, 32'h0);
        check("mr_busy", {31'd0, busy}, 32'h0);
        ticks(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
